systolic_seq_ctrl: RTL and testbench

Sequencer for the N×N systolic array of `pe` cells. On a start command it clears the array and optionally loads bias. It then streams skewed operand indices into the row and column edges, waits for the accumulators to settle, and pulses a completion strobe. Results can be captured on that strobe. It sits between the register-file/APB command logic and the PE array, and is the only driver of the array's `done` and `mode_bit` inputs.

---
 rtl/systolic_seq_ctrl_pkg.sv | 38 +++
 rtl/systolic_seq_ctrl_skew.sv | 25 ++
 rtl/systolic_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the systolic array sequencer.
package systolic_seq_ctrl_pkg;

  // Array geometry.
  localparam int MAX_DIM   = 4;
  localparam int IDX_WIDTH = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int DIM_WIDTH = $clog2(MAX_DIM + 1);

  // Phase counter must hold the last FEED step, 3*MAX_DIM-3.
  localparam int T_WIDTH = (3 * MAX_DIM - 2 > 1) ? $clog2(3 * MAX_DIM - 2) : 1;

  // Fixed phase lengths in cycles.
  localparam int CLEAR_CYCLES = 1;
  localparam int BIAS_CYCLES  = 1;
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_BIAS,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Overflow bits of PEs outside the active N x N corner are ignored.
  function automatic logic [MAX_DIM*MAX_DIM-1:0] active_pe_mask(input logic [DIM_WIDTH-1:0] n);
    logic [MAX_DIM*MAX_DIM-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      for (int j = 0; j < MAX_DIM; j++) begin
        m[i*MAX_DIM+j] = (i < int'(n)) && (j < int'(n));
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew.sv
// Skewed operand index generator: lane g sees k = t - g while 0 <= k < N.
module skew_index_gen
  import systolic_seq_ctrl_pkg::*;
(
  input  logic                         en_i,
  input  logic [T_WIDTH-1:0]           t_i,
  input  logic [DIM_WIDTH-1:0]         n_i,
  output logic [MAX_DIM-1:0]           valid_o,
  output logic [MAX_DIM*IDX_WIDTH-1:0] idx_o
);

  genvar gi;
  generate
    for (gi = 0; gi < MAX_DIM; gi++) begin : g_lane
      int   k;
      logic in_range;
      assign k        = int'(t_i) - gi;
      // Lanes at or beyond N never carry data; idx is forced to 0 when idle.
      assign in_range = en_i && (gi < int'(n_i)) && (k >= 0) && (k < int'(n_i));
      assign valid_o[gi] = in_range;
      assign idx_o[gi*IDX_WIDTH +: IDX_WIDTH] = in_range ? IDX_WIDTH'(k) : '0;
    end
  endgenerate

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the N x N systolic array: clear, optional bias load, skewed
// operand streaming, drain, and a one-cycle completion strobe.
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DIM_WIDTH-1:0]         dim,
  input  logic                         bias_en,
  input  logic [MAX_DIM*MAX_DIM-1:0]   pe_overflow,
  output logic                         pe_done,
  output logic                         pe_mode,
  output logic [MAX_DIM-1:0]           a_valid,
  output logic [MAX_DIM*IDX_WIDTH-1:0] a_idx,
  output logic [MAX_DIM-1:0]           b_valid,
  output logic [MAX_DIM*IDX_WIDTH-1:0] b_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         ovf,
  output logic                         cfg_err
);

  state_e                 state_q, state_d;
  logic [T_WIDTH-1:0]     cnt_q, cnt_d;
  logic [DIM_WIDTH-1:0]   n_q, n_d;
  logic                   bias_q, bias_d;
  logic                   ovf_q, ovf_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   dim_ok;
  logic [T_WIDTH-1:0]     feed_last;
  logic                   feed_d;

  // Every output is registered from the next-state view, so each output
  // reflects the state the sequencer occupies in that same cycle.
  logic                         pe_done_q, pe_mode_q, busy_q, done_q;
  logic [MAX_DIM-1:0]           a_valid_d, b_valid_d, a_valid_q, b_valid_q;
  logic [MAX_DIM*IDX_WIDTH-1:0] a_idx_d, b_idx_d, a_idx_q, b_idx_q;

  assign dim_ok    = (dim != '0) && (dim <= DIM_WIDTH'(MAX_DIM));
  assign feed_last = T_WIDTH'(3 * int'(n_q) - 3);
  assign feed_d    = (state_d == ST_FEED);

  // Next-state, phase counter, latched command and sticky overflow.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    bias_d    = bias_q;
    ovf_d     = ovf_q;
    cfg_err_d = 1'b0;
    if (state_q inside {ST_FEED, ST_DRAIN, ST_DONE}) begin
      ovf_d = ovf_q | (|(pe_overflow & active_pe_mask(n_q)));
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dim_ok) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            n_d     = dim;
            bias_d  = bias_en;
            ovf_d   = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (cnt_q == T_WIDTH'(CLEAR_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = bias_q ? ST_BIAS : ST_FEED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BIAS: begin
        if (cnt_q == T_WIDTH'(BIAS_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_FEED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FEED: begin
        if (cnt_q == feed_last) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == T_WIDTH'(DRAIN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  skew_index_gen u_row_skew (
    .en_i    (feed_d),
    .t_i     (cnt_d),
    .n_i     (n_d),
    .valid_o (a_valid_d),
    .idx_o   (a_idx_d)
  );

  skew_index_gen u_col_skew (
    .en_i    (feed_d),
    .t_i     (cnt_d),
    .n_i     (n_d),
    .valid_o (b_valid_d),
    .idx_o   (b_idx_d)
  );

  // State and output registers; reset forces IDLE with every output low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      bias_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      pe_done_q <= 1'b0;
      pe_mode_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_valid_q <= '0;
      a_idx_q   <= '0;
      b_valid_q <= '0;
      b_idx_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      bias_q    <= bias_d;
      ovf_q     <= ovf_d;
      cfg_err_q <= cfg_err_d;
      pe_done_q <= (state_d == ST_CLEAR);
      pe_mode_q <= bias_d && (state_d inside {ST_BIAS, ST_FEED, ST_DRAIN, ST_DONE});
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      a_valid_q <= a_valid_d;
      a_idx_q   <= a_idx_d;
      b_valid_q <= b_valid_d;
      b_idx_q   <= b_idx_d;
    end
  end

  assign pe_done = pe_done_q;
  assign pe_mode = pe_mode_q;
  assign a_valid = a_valid_q;
  assign a_idx   = a_idx_q;
  assign b_valid = b_valid_q;
  assign b_idx   = b_idx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: a cycle-timeline model derived
// from the run length formula, directed scenarios and randomized commands.
module tb_systolic_seq_ctrl;
  import systolic_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, bias_en;
  logic [2:0]  dim;
  logic [15:0] pe_overflow;
  logic        pe_done, pe_mode, busy, done, ovf, cfg_err;
  logic [3:0]  a_valid, b_valid;
  logic [7:0]  a_idx, b_idx;

  always #5 clk = ~clk;

  systolic_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dim         (dim),
    .bias_en     (bias_en),
    .pe_overflow (pe_overflow),
    .pe_done     (pe_done),
    .pe_mode     (pe_mode),
    .a_valid     (a_valid),
    .a_idx       (a_idx),
    .b_valid     (b_valid),
    .b_idx       (b_idx),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf),
    .cfg_err     (cfg_err)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int done_cnt  = 0;

  // Model: a run is described only by r, the cycle count since the accepting
  // edge (CLEAR is r=1), plus the latched N and bias flag.
  bit model_ok = 1'b0;
  bit m_act    = 1'b0;
  int m_r      = 0;
  int m_n      = 0;
  int m_b      = 0;
  bit m_ovf    = 1'b0;
  bit m_cfg    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic logic [29:0] expect_out();
    logic       pd, pm, bz, dn;
    logic [3:0] av;
    logic [7:0] ai;
    int         t;
    pd = 1'b0; pm = 1'b0; bz = 1'b0; dn = 1'b0; av = '0; ai = '0;
    if (m_act) begin
      bz = 1'b1;
      pd = (m_r == 1);
      pm = (m_b == 1) && (m_r >= 2);
      dn = (m_r == 3 * m_n + 2 + m_b);
      t  = m_r - (2 + m_b);
      if (t >= 0 && t <= 3 * m_n - 3) begin
        for (int i = 0; i < 4; i++) begin
          if (i < m_n && t - i >= 0 && t - i < m_n) begin
            av[i]        = 1'b1;
            ai[i*2 +: 2] = 2'(t - i);
          end
        end
      end
    end
    return {pd, pm, av, ai, av, ai, bz, dn, m_ovf, m_cfg};
  endfunction

  function automatic void model_edge(input bit rst, input bit st, input int d, input bit b,
                                     input logic [15:0] ov);
    if (rst) begin
      model_ok = 1'b1; m_act = 1'b0; m_r = 0; m_ovf = 1'b0; m_cfg = 1'b0;
      return;
    end
    if (!model_ok) return;
    if (!m_act) begin
      m_cfg = st && !(d >= 1 && d <= 4);
      if (st && d >= 1 && d <= 4) begin
        m_act = 1'b1; m_r = 1; m_n = d; m_b = int'(b); m_ovf = 1'b0;
      end
    end else begin
      m_cfg = 1'b0;
      if (m_r >= 2 + m_b) begin
        for (int i = 0; i < m_n; i++)
          for (int j = 0; j < m_n; j++)
            if (ov[i*4+j]) m_ovf = 1'b1;
      end
      if (m_r == 3 * m_n + 2 + m_b) m_act = 1'b0;
      else m_r++;
    end
  endfunction

  // Compare this cycle's outputs, then drive the inputs for this cycle.
  task automatic step(input bit rst, input bit st, input int d, input bit b, input logic [15:0] ov);
    logic [29:0] obs;
    @(negedge clk);
    cyc++;
    if (model_ok) begin
      obs = {pe_done, pe_mode, a_valid, a_idx, b_valid, b_idx, busy, done, ovf, cfg_err};
      chk($sformatf("cycle %0d outputs", cyc), 32'(obs), 32'(expect_out()));
      if (done === 1'b1) done_cnt++;
    end
    reset = rst; start = st; dim = 3'(d); bias_en = b; pe_overflow = ov;
    model_edge(rst, st, d, b, ov);
  endtask

  initial begin
    bit          r_rst, r_st, r_b;
    int          r_d, done_before;
    logic [15:0] r_ov;

    reset = 1'b1; start = 1'b0; dim = '0; bias_en = 1'b0; pe_overflow = '0;
    step(1, 0, 0, 0, 16'h0);
    step(1, 1, 2, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    chk("reset state", 32'({pe_done, pe_mode, a_valid, a_idx, b_valid, b_idx, busy, done, ovf, cfg_err}), 32'd0);

    // N=1, no bias.
    step(0, 1, 1, 0, 16'h0);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 0, 0, 16'h0);
      if (k == 1) chk("n1 pe_done", 32'({pe_done, busy}), 32'b11);
      if (k == 2) chk("n1 feed", 32'({a_valid, b_valid, a_idx, b_idx}), 32'h1100_00);
      if (k == 5) chk("n1 done", 32'({busy, done}), 32'b11);
      if (k == 6) chk("n1 idle", 32'({busy, done}), 32'b00);
    end

    // N=4, no bias: t=3 fans idx 3,2,1,0 across rows 0..3.
    step(0, 1, 4, 0, 16'h0);
    for (int k = 1; k <= 15; k++) begin
      step(0, 0, 0, 0, 16'h0);
      if (k == 5)  chk("n4 t3 rows", 32'({a_valid, a_idx}), 32'hF1B);
      if (k == 13) chk("n4 pre-done", 32'(done), 32'd0);
      if (k == 14) chk("n4 done", 32'(done), 32'd1);
    end

    // N=2 with bias.
    step(0, 1, 2, 1, 16'h0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0, 0, 16'h0);
      if (k == 2) chk("n2 bias phase", 32'({pe_mode, a_valid, b_valid}), 32'h100);
      if (k == 3) chk("n2 first feed", 32'({pe_mode, a_valid}), 32'h11);
      if (k == 9) chk("n2 bias done", 32'({done, pe_mode}), 32'b11);
    end

    // Rejected dimensions.
    step(0, 1, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    chk("dim0 cfg_err", 32'({cfg_err, busy}), 32'b10);
    step(0, 1, 5, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    chk("dim5 cfg_err", 32'({cfg_err, busy}), 32'b10);
    step(0, 0, 0, 0, 16'h0);
    chk("cfg_err one cycle", 32'(cfg_err), 32'd0);

    // Start during FEED is ignored.
    step(0, 1, 3, 0, 16'h0);
    for (int k = 1; k <= 12; k++) begin
      step(0, (k == 4), 2, 1, 16'h0);
      if (k == 5)  chk("busy start no cfg_err", 32'(cfg_err), 32'd0);
      if (k == 11) chk("n3 done unchanged", 32'({done, pe_mode}), 32'b10);
    end

    // Reset during FEED t=2, then N=3 run.
    step(0, 1, 4, 0, 16'h0);
    for (int k = 1; k <= 5; k++) begin
      step((k == 4), 0, 0, 0, 16'h0);
      if (k == 4) chk("feed t2 rows", 32'({a_valid, a_idx}), 32'h706);
      if (k == 5) chk("reset mid-run", 32'({pe_done, pe_mode, a_valid, a_idx, b_valid, b_idx, busy, done, ovf, cfg_err}), 32'd0);
    end
    step(0, 1, 3, 0, 16'h0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, 0, 16'h0);
      if (k == 11) chk("n3 after reset done", 32'(done), 32'd1);
    end

    // Overflow on PE(1,1) during DRAIN is captured and held.
    step(0, 1, 2, 0, 16'h0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0, 0, (k == 6) ? 16'h0020 : 16'h0000);
      if (k == 8)  chk("ovf at done", 32'({done, ovf}), 32'b11);
      if (k == 10) chk("ovf held idle", 32'({busy, ovf}), 32'b01);
    end
    // Overflow on PE(3,3) is outside N=2 and is masked.
    step(0, 1, 2, 0, 16'h0);
    for (int k = 1; k <= 9; k++) begin
      step(0, 0, 0, 0, (k == 6) ? 16'h8000 : 16'h0000);
      if (k == 1) chk("ovf cleared on start", 32'(ovf), 32'd0);
      if (k == 8) chk("ovf masked", 32'({done, ovf}), 32'b10);
    end

    // Randomized commands, overflow pulses and occasional resets.
    done_before = done_cnt;
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_st  = ($urandom_range(0, 5) == 0);
      r_d   = int'($urandom_range(0, 7));
      r_b   = 1'($urandom_range(0, 1));
      r_ov  = ($urandom_range(0, 7) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
      step(r_rst, r_st, r_d, r_b, r_ov);
    end
    for (int n = 0; n < 20; n++) step(0, 0, 0, 0, 16'h0);
    chk("random runs completed", 32'(done_cnt > done_before), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
